// File: rtl/timer_pkg.sv
// Shared definitions for the two-mode timer: state encoding and default sizing.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 25;
  localparam int unsigned DEFAULT_DIV = 50_000_000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the system clock down to one tick every DIV enabled cycles.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // clear dominates enable so a reload always restarts a full tick period
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer25.sv
// Down-counting core of the two-mode timer: loads a preset, decrements per
// prescaled tick while running, flags expiry with a done pulse and sticky level.
module countdown_timer25
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH,
  parameter int unsigned DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expired
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             running_q, expired_q;
  logic             psc_clear, psc_en, tick;

  // Prescaler control is decoded from registered state and raw requests only,
  // so the tick fed back into the next-state logic forms no combinational loop.
  assign psc_clear = load || (state_q == IDLE) || (state_q == EXPIRED);
  assign psc_en    = (state_q == RUN) && !load && !pause;

  timer_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (psc_clear),
    .enable(psc_en),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          count_d = load_value;
        end else if (start) begin
          if (count_q == '0) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN, PAUSED: begin
        if (load) begin
          count_d = load_value;
          if (load_value == '0) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end else if (pause) begin
          state_d = PAUSED;
        end else if (state_q == PAUSED) begin
          if (start) state_d = RUN;
        end else if (tick) begin
          // a zero count never decrements; it just expires
          if ((count_q == WIDTH'(1)) || (count_q == '0)) begin
            count_d = '0;
            state_d = EXPIRED;
            done_d  = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      EXPIRED: begin
        count_d = '0;
        if (load) begin
          count_d = load_value;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer25.sv
// Directed bench for countdown_timer25 with DIV=4: vector table plus hand sequences.
module tb_countdown_timer25;

  localparam int unsigned W = 25;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic [W-1:0] count;
  logic         running;
  logic         done;
  logic         expired;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        name;
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         pa;
    logic [W-1:0] c;
    logic         r;
    logic         d;
    logic         e;
  } vec_t;

  vec_t vecs[$];

  countdown_timer25 #(
    .WIDTH(W),
    .DIV  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .pause     (pause),
    .count     (count),
    .running   (running),
    .done      (done),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic st, input logic pa);
    load       = ld;
    load_value = lv;
    start      = st;
    pause      = pa;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [W-1:0] c, input logic r,
                       input logic d, input logic e);
    total++;
    if ({count, running, done, expired} !== {c, r, d, e}) begin
      bad++;
      $display("FAIL %s: got count=%h run=%b done=%b exp=%b, want count=%h run=%b done=%b exp=%b",
               name, count, running, done, expired, c, r, d, e);
    end
  endtask

  task automatic add(input string name, input logic ld, input logic [W-1:0] lv, input logic st,
                     input logic pa, input logic [W-1:0] c, input logic r, input logic d,
                     input logic e);
    vec_t v;
    v.name = name; v.ld = ld; v.lv = lv; v.st = st; v.pa = pa;
    v.c = c; v.r = r; v.d = d; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    step();
    check("reset_hold", '0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;

    // Plan 1: load 3, start, decrements at 4/8/12 edges after start
    add("t1_load3", 1, 3, 0, 0, 3, 0, 0, 0);
    add("t1_start", 0, 0, 1, 0, 3, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      if (i < 4)       add($sformatf("t1_e%0d", i), 0, 0, 0, 0, 3, 1, 0, 0);
      else if (i < 8)  add($sformatf("t1_e%0d", i), 0, 0, 0, 0, 2, 1, 0, 0);
      else if (i < 12) add($sformatf("t1_e%0d", i), 0, 0, 0, 0, 1, 1, 0, 0);
      else             add("t1_zero_done", 0, 0, 0, 0, 0, 0, 1, 1);
    end
    add("t1_done_drops", 0, 0, 0, 0, 0, 0, 0, 1);
    add("t1_start_ignored", 0, 0, 1, 0, 0, 0, 0, 1);
    add("t1_pause_ignored", 0, 0, 0, 1, 0, 0, 0, 1);
    // Plan 3: start with count 0
    add("t3_load0_idle", 1, 0, 0, 0, 0, 0, 0, 0);
    add("t3_idle_pause", 0, 0, 0, 1, 0, 0, 0, 0);
    add("t3_start0", 0, 0, 1, 0, 0, 0, 1, 1);
    add("t3_after", 0, 0, 0, 0, 0, 0, 0, 1);
    add("t3_restart", 0, 0, 1, 0, 0, 0, 0, 1);
    add("t3_restart2", 0, 0, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa);
      step();
      check(vecs[i].name, vecs[i].c, vecs[i].r, vecs[i].d, vecs[i].e);
    end

    // Plan 2: pause with prescaler at 2, resume decrements 2 edges later
    drive(1, 5, 0, 0); step(); check("t2_load5", 5, 0, 0, 1'b0);
    drive(0, 0, 1, 0); step(); check("t2_start", 5, 1, 0, 0);
    idle();
    for (int i = 1; i <= 6; i++) step();
    check("t2_before_pause", 4, 1, 0, 0);
    drive(0, 0, 0, 1); step(); check("t2_pause", 4, 0, 0, 0);
    idle();
    for (int i = 0; i < 10; i++) step();
    check("t2_frozen", 4, 0, 0, 0);
    drive(0, 0, 1, 0); step(); check("t2_resume", 4, 1, 0, 0);
    idle();
    step(); check("t2_resume_e1", 4, 1, 0, 0);
    step(); check("t2_resume_e2", 3, 1, 0, 0);
    step(); check("t2_resume_e3", 3, 1, 0, 0);

    // Plan 4: load+pause together at count 7, then load 0 from PAUSED
    drive(1, 8, 0, 0); step(); check("t4_load8_run", 8, 1, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) step();
    check("t4_count7", 7, 1, 0, 0);
    step();
    drive(1, 9, 0, 1); step(); check("t4_load9_pause", 9, 0, 0, 0);
    drive(0, 0, 1, 0); step(); check("t4_resume", 9, 1, 0, 0);
    idle();
    step(); step();
    step(); check("t4_psc_cleared", 9, 1, 0, 0);
    step(); check("t4_first_dec", 8, 1, 0, 0);
    drive(0, 0, 0, 1); step(); check("t4_pause2", 8, 0, 0, 0);
    drive(1, 0, 0, 0); step(); check("t4_load0_done", 0, 0, 1, 1);
    idle(); step(); check("t4_done_once", 0, 0, 0, 1);

    // Plan 5: max preset, no overflow, async reset mid-prescale
    drive(1, 25'h1FFFFFF, 0, 0); step(); check("t5_load_max", 25'h1FFFFFF, 0, 0, 0);
    drive(0, 0, 1, 0); step(); check("t5_start", 25'h1FFFFFF, 1, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) step();
    check("t5_dec_max", 25'h1FFFFFE, 1, 0, 0);
    step();
    #2 rst = 1'b0;
    #1 check("t5_async_reset", '0, 0, 0, 0);
    step(); step();
    rst = 1'b1;
    step(); check("t5_after_reset", '0, 0, 0, 0);
    drive(0, 0, 1, 0); step(); check("t5_idle_start0", '0, 0, 1, 1);
    idle(); step(); check("t5_idle_after", '0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
